fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers. Each cycle it selects at most one requester, drives the FIFO write enable and data (tagged with the source ID), and returns a per-requester ready. Burst holding lets a requester keep the port for up to MAX_BURST consecutive writes before it must yield to waiting requesters. The block sits directly in front of the FIFO's `w_en`/`data_in`/`full` pins; the FIFO read side is untouched.

## Interface
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 8, payload width per producer.
- MAX_BURST, 4, max consecutive writes granted to one owner while others wait (>=1).
- ID_WIDTH, $clog2(NUM_REQ) (derived, localparam), source-tag width.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  bit i: producer i has a word to write.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; bit i high = producer i's word is written this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  ID_WIDTH+DATA_WIDTH  {winner ID, winner payload}; zero when fifo_w_en low.
- grant_id  out  ID_WIDTH  current winner ID; zero when no winner.

## Operation
- Registered state: owner (ID_WIDTH), active (1), burst_cnt ($clog2(MAX_BURST+1) bits). Reset: owner=NUM_REQ-1, active=0, burst_cnt=0.
- Winner selection (combinational from state and req_valid):
  - If active, req_valid[owner]=1 and burst_cnt<MAX_BURST: winner=owner.
  - Else: first i with req_valid[i]=1 scanning owner+1, owner+2, ... modulo NUM_REQ, ending with owner itself (owner wins only if nobody else is valid).
  - No valid requester: no winner.
- Transfer = winner exists && !fifo_full. On transfer: fifo_w_en=1, req_ready[winner]=1, fifo_data_in={winner, payload}.
- State update on transfer: if winner==owner && active && burst_cnt<MAX_BURST then burst_cnt+1, else burst_cnt=1; owner=winner; active=1.
- No transfer because fifo_full: all state held; winner may still change if req_valid changes.
- No transfer because no valid: active=0, burst_cnt=0, owner held (RR pointer preserved).
- Producer dropping valid mid-burst ends its ownership (next winner from scan).
- Producers must hold req_valid/req_data stable until req_ready seen; block does not check this.

## Timing
- Zero-latency: req_ready, fifo_w_en, fifo_data_in, grant_id are combinational from state, req_valid, req_data, fifo_full; FIFO captures on the same edge the state updates.
- Combinational path fifo_full -> req_ready/fifo_w_en permitted; req_ready never depends on req_ready.
- While rst_n=0: all outputs forced to 0 regardless of inputs; state takes reset values at the edge. Reset mid-burst discards ownership; first post-reset scan starts at requester 0.
- Never writes when fifo_full=1; at most one write per cycle.
- All valid continuously, FIFO never full: grant order repeats MAX_BURST×0, MAX_BURST×1, ... MAX_BURST×(NUM_REQ-1).

## Test plan
- Reset: rst_n=0 with all req_valid=1 -> req_ready=0, fifo_w_en=0, fifo_data_in=0; release -> first write from ID 0.
- Fairness: NUM_REQ=4, MAX_BURST=4, all valid, full=0 for 16 cycles -> grant_id 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
- Lone requester: only req_valid[2]=1 for 10 cycles -> 10 consecutive writes, tag 2, burst restarts after 4 with no gap.
- Backpressure: all valid, fifo_full=1 at cycle 2 of owner 1's burst for 3 cycles -> no writes, req_ready=0; on release owner 1 completes remaining 2 writes then ID 2.
- Early drop: owner 0 drops valid after 2 writes with 1 and 3 valid -> next grant ID 1; with only 3 valid -> ID 3.
- Data/tag integrity: distinct payloads 0xA0+i per producer -> every FIFO word equals {i, 0xA0+i}; scoreboard count matches req_ready pulses.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// It supports burst holding: an owner may keep the port for up to MAX_BURST writes while others wait.
module fifo_wr_arbiter #(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_w_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_in,
  output logic [ID_WIDTH-1:0]            grant_id
);

  localparam int unsigned           CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0]  MAX_CNT   = CNT_WIDTH'(MAX_BURST);

  logic [ID_WIDTH-1:0]   owner;
  logic                  active;
  logic [CNT_WIDTH-1:0]  burst_cnt;

  logic                  win_valid;
  logic [ID_WIDTH-1:0]   win_id;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  xfer;
  logic                  burst_open;
  int unsigned           idx;

  assign burst_open = active && (burst_cnt < MAX_CNT);

  // The scan starts just past the owner and ends on the owner itself.
  // As a result, an exhausted owner wins again only when nobody else is waiting.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (burst_open && req_valid[owner]) begin
      win_valid = 1'b1;
      win_id    = owner;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (32'(owner) + k) % NUM_REQ;
        if (!win_valid && req_valid[idx]) begin
          win_valid = 1'b1;
          win_id    = ID_WIDTH'(idx);
        end
      end
    end
  end

  assign win_data = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign xfer     = rst_n && win_valid && !fifo_full;

  always_comb begin
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    grant_id     = '0;
    if (rst_n && win_valid) grant_id = win_id;
    if (xfer) begin
      req_ready[win_id] = 1'b1;
      fifo_w_en         = 1'b1;
      fifo_data_in      = {win_id, win_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= ID_WIDTH'(NUM_REQ - 1);
      active    <= 1'b0;
      burst_cnt <= '0;
    end else if (xfer) begin
      if (win_id == owner && burst_open) burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      else                               burst_cnt <= CNT_WIDTH'(1);
      owner  <= win_id;
      active <= 1'b1;
    end else if (!win_valid) begin
      active    <= 1'b0;
      burst_cnt <= '0;
    end
  end

endmodule
